// File: rtl/cache_set_pkg.sv
// cache_set_pkg -- shared encodings for one set of the L1 data cache.
//
// Contents:
//   op_e       operation encodings (OP_READ, OP_WRITE, OP_NOP)
//   size_e     access size encodings (SZ_8, SZ_16, SZ_32, SZ_64)
//   LINE_BYTES line size in bytes
//   OFFSET_W   byte-offset width within a line
//   size_mask  64-bit mask covering the low bytes of an access of a given size
package cache_set_pkg;

   typedef enum logic [1:0] {
      OP_READ  = 2'd0,
      OP_WRITE = 2'd1,
      OP_NOP   = 2'd2
   } op_e;

   typedef enum logic [1:0] {
      SZ_8  = 2'd0,
      SZ_16 = 2'd1,
      SZ_32 = 2'd2,
      SZ_64 = 2'd3
   } size_e;

   localparam int LINE_BYTES = 64;
   localparam int OFFSET_W   = $clog2(LINE_BYTES);

   function automatic logic [63:0] size_mask(input logic [1:0] sz);
      logic [63:0] m;
      case (size_e'(sz))
         SZ_8:    m = 64'h0000_0000_0000_00FF;
         SZ_16:   m = 64'h0000_0000_0000_FFFF;
         SZ_32:   m = 64'h0000_0000_FFFF_FFFF;
         default: m = 64'hFFFF_FFFF_FFFF_FFFF;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/cache_set_lru.sv
// cache_set_lru -- true-LRU age counters for one cache set.
//
// Ports:
//   clk        clock
//   rst_n      synchronous active-low reset (all ages -> 0)
//   touch      a way is being accessed this cycle
//   touch_way  index of the accessed way
//   valid      current valid vector of the set
//   victim     lowest-index invalid way, or the oldest valid way when full
module cache_set_lru #(
   parameter  int WAYS  = 8,
   localparam int WAY_W = $clog2(WAYS)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             touch,
   input  logic [WAY_W-1:0] touch_way,
   input  logic [WAYS-1:0]  valid,
   output logic [WAY_W-1:0] victim
);

   logic [WAY_W-1:0] age [WAYS];
   logic [WAY_W-1:0] max_age;
   logic             found_inv;

   // A way being allocated (currently invalid) counts as older than every
   // resident line, so all valid ways age by one. Resident ages therefore
   // stay distinct and become a permutation once the set is full.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < WAYS; i++) age[i] <= '0;
      end else if (touch) begin
         for (int i = 0; i < WAYS; i++) begin
            if (touch_way == WAY_W'(i))
               age[i] <= '0;
            else if (valid[i] && (!valid[touch_way] || age[i] < age[touch_way]))
               age[i] <= age[i] + 1'b1;
         end
      end
   end

   // NOTE: every variable gets a default at the top of always_comb so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      victim    = '0;
      max_age   = '0;
      found_inv = 1'b0;
      for (int i = 0; i < WAYS; i++) begin
         if (!valid[i] && !found_inv) begin
            victim    = WAY_W'(i);
            found_inv = 1'b1;
         end
      end
      if (!found_inv) begin
         max_age = age[0];
         // Strict '>' keeps the lowest index on ties.
         for (int i = 1; i < WAYS; i++) begin
            if (age[i] > max_age) begin
               max_age = age[i];
               victim  = WAY_W'(i);
            end
         end
      end
   end

endmodule

// File: rtl/cache_set.sv
// cache_set -- one set of an 8-way, 64-byte-line, write-back/write-allocate
// L1 data cache with true-LRU replacement.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   enable, op          operation strobe and opcode (read/write/no-op)
//   block_offset        byte offset within the line (aligned down to size)
//   set_n               set index; only SET_ID is accepted
//   write_data          LSB-aligned write data
//   data_size           access size 8/16/32/64 bits
//   tag                 address tag
//   out_data            registered read data, zero-extended
//   data_ready          read hit
//   miss_r, miss_w      read miss / write miss (line allocated)
//   evict_valid/dirty/tag  information about a replaced valid line
//   num_ops             accepted-op counter (only with CACHE_SET_OPCOUNT_EN)
//
// Build option: define CACHE_SET_OPCOUNT_EN to add the num_ops output.
module cache_set #(
   parameter  int WAYS       = 8,
   parameter  int TAG_W      = 24,
   parameter  int LINE_BYTES = 64,
   parameter  int SET_ID     = 0,
   localparam int WAY_W      = $clog2(WAYS),
   localparam int OFF_W      = $clog2(LINE_BYTES),
   localparam int LINE_W     = LINE_BYTES * 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic [1:0]       op,
   input  logic [OFF_W-1:0] block_offset,
   input  logic [5:0]       set_n,
   input  logic [63:0]      write_data,
   input  logic [1:0]       data_size,
   input  logic [TAG_W-1:0] tag,
   output logic [63:0]      out_data,
   output logic             data_ready,
   output logic             miss_r,
   output logic             miss_w,
   output logic             evict_valid,
   output logic             evict_dirty,
   output logic [TAG_W-1:0] evict_tag
`ifdef CACHE_SET_OPCOUNT_EN
   ,
   output logic [31:0]      num_ops
`endif
);

   import cache_set_pkg::OP_READ;
   import cache_set_pkg::OP_WRITE;
   import cache_set_pkg::size_mask;

   logic [TAG_W-1:0]  tags  [WAYS];
   logic [LINE_W-1:0] lines [WAYS];
   logic [WAYS-1:0]   valid;
   logic [WAYS-1:0]   dirty;

   logic              accepted;
   logic              is_write;
   logic              hit;
   logic [WAY_W-1:0]  hit_way;
   logic [WAY_W-1:0]  victim;
   logic [WAY_W-1:0]  tgt_way;
   logic              touch;
   logic [OFF_W-1:0]  low_bits;
   logic [OFF_W-1:0]  eff_off;
   logic [OFF_W+2:0]  bit_sh;
   logic [63:0]       smask;
   logic [63:0]       rd_data;
   logic [LINE_W-1:0] base_line;
   logic [LINE_W-1:0] wr_line;

   always_comb begin
      accepted = enable && (op == OP_READ || op == OP_WRITE) && (set_n == 6'(SET_ID));
      is_write = (op == OP_WRITE);

      hit     = 1'b0;
      hit_way = '0;
      for (int i = 0; i < WAYS; i++) begin
         if (valid[i] && tags[i] == tag) begin
            hit     = 1'b1;
            hit_way = WAY_W'(i);
         end
      end

      // Clearing the low data_size bits aligns the access so it never
      // crosses the line boundary.
      low_bits = (OFF_W'(1) << data_size) - OFF_W'(1);
      eff_off  = block_offset & ~low_bits;
      bit_sh   = {eff_off, 3'b000};
      smask    = size_mask(data_size);

      rd_data  = 64'(lines[hit_way] >> bit_sh) & smask;

      // A write miss merges into a zero-filled victim line.
      tgt_way   = hit ? hit_way : victim;
      base_line = hit ? lines[hit_way] : '0;
      wr_line   = (base_line & ~(LINE_W'(smask) << bit_sh))
                | (LINE_W'(write_data & smask) << bit_sh);

      // Read misses neither allocate nor age the set.
      touch = accepted && (hit || is_write);
   end

   cache_set_lru #(
      .WAYS (WAYS)
   ) u_lru (
      .clk       (clk),
      .rst_n     (rst_n),
      .touch     (touch),
      .touch_way (tgt_way),
      .valid     (valid),
      .victim    (victim)
   );

   // NOTE: tag and data arrays are not reset; valid=0 makes their contents
   // unobservable, and leaving them out of reset lets them map to plain RAM.
   always_ff @(posedge clk) begin
      if (rst_n && accepted && is_write) begin
         lines[tgt_way] <= wr_line;
         if (!hit) tags[tgt_way] <= tag;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // right-hand side sees the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid       <= '0;
         dirty       <= '0;
         out_data    <= '0;
         data_ready  <= 1'b0;
         miss_r      <= 1'b0;
         miss_w      <= 1'b0;
         evict_valid <= 1'b0;
         evict_dirty <= 1'b0;
         evict_tag   <= '0;
      end else begin
         data_ready  <= 1'b0;
         miss_r      <= 1'b0;
         miss_w      <= 1'b0;
         evict_valid <= 1'b0;
         evict_dirty <= 1'b0;
         if (accepted) begin
            if (!is_write) begin
               data_ready <= hit;
               miss_r     <= !hit;
               out_data   <= hit ? rd_data : 64'd0;
            end else begin
               dirty[tgt_way] <= 1'b1;
               if (!hit) begin
                  miss_w         <= 1'b1;
                  valid[tgt_way] <= 1'b1;
                  evict_valid    <= valid[tgt_way];
                  evict_dirty    <= valid[tgt_way] & dirty[tgt_way];
                  evict_tag      <= tags[tgt_way];
               end
            end
         end
      end
   end

`ifdef CACHE_SET_OPCOUNT_EN
   always_ff @(posedge clk) begin
      if (!rst_n)        num_ops <= '0;
      else if (accepted) num_ops <= num_ops + 32'd1;
   end
`endif

endmodule

// File: tb/tb_cache_set.sv
// tb_cache_set -- randomized, scoreboard-checked bench for cache_set.
// Reference model: per-way byte arrays plus a recency queue (MRU first).
module tb_cache_set;

   localparam int WAYS   = 8;
   localparam int TAG_W  = 24;
   localparam int SET_ID = 3;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             enable = 1'b0;
   logic [1:0]       op = 2'd2;
   logic [5:0]       block_offset = '0;
   logic [5:0]       set_n = '0;
   logic [63:0]      write_data = '0;
   logic [1:0]       data_size = '0;
   logic [TAG_W-1:0] tag = '0;
   logic [63:0]      out_data;
   logic             data_ready, miss_r, miss_w;
   logic             evict_valid, evict_dirty;
   logic [TAG_W-1:0] evict_tag;
`ifdef CACHE_SET_OPCOUNT_EN
   logic [31:0]      num_ops;
`endif

   cache_set #(
      .WAYS       (WAYS),
      .TAG_W      (TAG_W),
      .LINE_BYTES (64),
      .SET_ID     (SET_ID)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .enable       (enable),
      .op           (op),
      .block_offset (block_offset),
      .set_n        (set_n),
      .write_data   (write_data),
      .data_size    (data_size),
      .tag          (tag),
      .out_data     (out_data),
      .data_ready   (data_ready),
      .miss_r       (miss_r),
      .miss_w       (miss_w),
      .evict_valid  (evict_valid),
      .evict_dirty  (evict_dirty),
      .evict_tag    (evict_tag)
`ifdef CACHE_SET_OPCOUNT_EN
      ,
      .num_ops      (num_ops)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      longint unsigned  due;
      logic [63:0]      od;
      bit               dr, mr, mw, ev, ed;
      logic [TAG_W-1:0] et;
      logic [31:0]      nops;
   } exp_t;

   exp_t            exp_q[$];
   int              checks = 0;
   int              errors = 0;
   longint unsigned cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- reference model ----------------
   bit               m_valid [WAYS];
   bit               m_dirty [WAYS];
   logic [TAG_W-1:0] m_tag   [WAYS];
   byte unsigned     m_data  [WAYS][64];
   int               rec[$];
   logic [63:0]      m_out;
   int unsigned      m_nops;

   function automatic void model_reset();
      for (int w = 0; w < WAYS; w++) begin
         m_valid[w] = 0;
         m_dirty[w] = 0;
      end
      rec.delete();
      m_out  = '0;
      m_nops = 0;
   endfunction

   function automatic void model_touch(int w);
      for (int i = 0; i < rec.size(); i++) begin
         if (rec[i] == w) begin
            rec.delete(i);
            break;
         end
      end
      rec.push_front(w);
   endfunction

   function automatic exp_t model_step(bit rn, bit en, logic [1:0] o, logic [5:0] sn,
                                       logic [5:0] off, logic [1:0] sz,
                                       logic [63:0] wd, logic [TAG_W-1:0] t);
      exp_t        e;
      int          hw, v, n, eff;
      logic [63:0] val;
      e = '{default: 0};
      if (!rn) begin
         model_reset();
         return e;
      end
      e.od   = m_out;
      e.nops = m_nops;
      if (!(en && o <= 2'd1 && sn == 6'(SET_ID))) return e;
      m_nops++;
      n   = 1 << sz;
      eff = int'(off) & ~(n - 1);
      hw  = -1;
      for (int w = 0; w < WAYS; w++)
         if (m_valid[w] && m_tag[w] == t) hw = w;
      if (o == 2'd0) begin
         if (hw >= 0) begin
            val = '0;
            for (int i = 0; i < n; i++) val |= 64'(m_data[hw][eff + i]) << (8 * i);
            m_out = val;
            e.dr  = 1;
            model_touch(hw);
         end else begin
            m_out = '0;
            e.mr  = 1;
         end
         e.od = m_out;
      end else begin
         if (hw >= 0) v = hw;
         else begin
            v = -1;
            for (int w = 0; w < WAYS; w++)
               if (!m_valid[w] && v < 0) v = w;
            if (v < 0) v = rec[rec.size() - 1];
            if (m_valid[v]) begin
               e.ev = 1;
               e.ed = m_dirty[v];
               e.et = m_tag[v];
            end
            for (int i = 0; i < 64; i++) m_data[v][i] = 8'h00;
            m_valid[v] = 1;
            m_tag[v]   = t;
            e.mw       = 1;
         end
         for (int i = 0; i < n; i++) m_data[v][eff + i] = wd[8 * i +: 8];
         m_dirty[v] = 1;
         model_touch(v);
      end
      e.nops = m_nops;
      return e;
   endfunction

   // ---------------- checking ----------------
   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            e = exp_q.pop_front();
            check("out_data",    out_data,    e.od);
            check("data_ready",  64'(data_ready),  64'(e.dr));
            check("miss_r",      64'(miss_r),      64'(e.mr));
            check("miss_w",      64'(miss_w),      64'(e.mw));
            check("evict_valid", 64'(evict_valid), 64'(e.ev));
            check("evict_dirty", 64'(evict_dirty), 64'(e.ed));
            if (e.ev) check("evict_tag", 64'(evict_tag), 64'(e.et));
`ifdef CACHE_SET_OPCOUNT_EN
            check("num_ops", 64'(num_ops), 64'(e.nops));
`endif
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic drive(bit rn, bit en, logic [1:0] o, logic [5:0] sn, logic [5:0] off,
                        logic [1:0] sz, logic [63:0] wd, logic [TAG_W-1:0] t);
      exp_t e;
      @(posedge clk);
      #1;
      rst_n        = rn;
      enable       = en;
      op           = o;
      set_n        = sn;
      block_offset = off;
      data_size    = sz;
      write_data   = wd;
      tag          = t;
      e            = model_step(rn, en, o, sn, off, sz, wd, t);
      e.due        = cyc + 1;
      exp_q.push_back(e);
   endtask

   task automatic rd(logic [TAG_W-1:0] t, logic [5:0] off, logic [1:0] sz);
      drive(1, 1, 2'd0, 6'(SET_ID), off, sz, {$urandom, $urandom}, t);
   endtask

   task automatic wr(logic [TAG_W-1:0] t, logic [5:0] off, logic [1:0] sz, logic [63:0] wd);
      drive(1, 1, 2'd1, 6'(SET_ID), off, sz, wd, t);
   endtask

   task automatic do_reset();
      drive(0, 0, 2'd2, 6'(SET_ID), 6'd0, 2'd0, 64'd0, '0);
      drive(0, 0, 2'd2, 6'(SET_ID), 6'd0, 2'd0, 64'd0, '0);
   endtask

   initial begin : timeout
      #2_000_000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1);
   end

   initial begin : stim
      do_reset();

      // Miss on an empty set.
      rd(20, 0, 2'd3);

      // Two byte allocations, then read them back.
      wr(16, 0, 2'd0, 64'h3);
      wr(25, 0, 2'd0, 64'h8);
      rd(16, 0, 2'd0);
      rd(25, 0, 2'd0);

      // Unaligned 64-bit write lands at offset 8; narrower reads slice it.
      wr(7, 13, 2'd3, 64'h1122_3344_5566_7788);
      rd(7, 10, 2'd1);
      rd(7, 12, 2'd2);
      rd(7, 8, 2'd3);

      // Fill, refresh way holding tag 0, then force an LRU eviction.
      do_reset();
      for (int i = 0; i < 8; i++) wr(TAG_W'(i), 6'(i), 2'd0, 64'(i + 1));
      rd(0, 0, 2'd0);
      wr(8, 0, 2'd3, 64'hDEAD_BEEF_0000_0001);
      rd(1, 0, 2'd0);
      rd(8, 0, 2'd3);

      // Ops to another set or with enable low are ignored.
      drive(1, 1, 2'd1, 6'(SET_ID + 1), 0, 2'd3, 64'h55, 40);
      drive(1, 0, 2'd1, 6'(SET_ID), 0, 2'd3, 64'h66, 41);
      rd(40, 0, 2'd3);
      rd(41, 0, 2'd3);

      // Reset wins over a simultaneous write.
      drive(0, 1, 2'd1, 6'(SET_ID), 0, 2'd3, 64'h77, 50);
      rd(50, 0, 2'd3);

      // Randomized traffic over a small tag pool to exercise hits/evictions.
      for (int k = 0; k < 3000; k++) begin
         bit          rn, en;
         logic [1:0]  o;
         logic [5:0]  sn;
         rn = ($urandom_range(0, 399) != 0);
         en = ($urandom_range(0, 9) != 0);
         o  = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
         sn = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(0, 63)) : 6'(SET_ID);
         drive(rn, en, o, sn, 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3)),
               {$urandom, $urandom}, TAG_W'($urandom_range(0, 11)));
      end

      drive(1, 0, 2'd2, 6'(SET_ID), 0, 2'd0, 64'd0, '0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cache_set.md
Name: cache_set

Overview:
- One set of an Intel-i7-style L1 data cache: 8 ways, 64-byte lines, 24-bit tags, true-LRU replacement.
- Performs one aligned read or write of 8/16/32/64 bits per cycle against the addressed line. Reports hit/miss and returns read data one cycle later.
- Instantiated once per set index by the cache top level. Write-allocate, write-back; victim information goes to the next level.

Parameters:
- WAYS, 8, associativity (power of 2, 2..16)
- TAG_W, 24, tag width in bits
- LINE_BYTES, 64, line size in bytes (offset width = log2(LINE_BYTES) = 6)
- SET_ID, 0, set index this instance answers to

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- enable  in  1  operation strobe; 0 = idle
- op  in  2  0 = read, 1 = write, 2/3 = no-op
- block_offset  in  6  byte offset within line
- set_n  in  6  set index; operation executes only if set_n == SET_ID
- write_data  in  64  write data, LSB-aligned
- data_size  in  2  0 = 8b, 1 = 16b, 2 = 32b, 3 = 64b
- tag  in  TAG_W  address tag
- out_data  out  64  read data, zero-extended
- data_ready  out  1  read hit data valid
- miss_r  out  1  read missed
- miss_w  out  1  write missed (line allocated)
- evict_valid  out  1  a valid line was replaced this op
- evict_dirty  out  1  replaced line was dirty
- evict_tag  out  TAG_W  tag of replaced line

Behaviour:
- Accepted op: enable=1, op in {0,1}, set_n==SET_ID, sampled at rising edge. Anything else is idle.
- Idle cycles clear data_ready, miss_r, miss_w and evict_valid, and leave out_data and cache state unchanged.
- Reset (rst_n=0 at edge): all valid, dirty and LRU state = 0; out_data=0; all flags=0. Reset wins over a simultaneous op.
- Alignment: effective offset = block_offset with the low data_size bits cleared; an access never crosses a line. Byte order is little-endian: byte offset k = bits [8k+7:8k] of the line.
- Lookup: hit when a way is valid and its stored tag == tag. Tags are unique within the set.
- Read hit: out_data = selected bytes zero-extended, data_ready=1, miss_r=0; the hit way becomes MRU.
- Read miss: out_data=0, data_ready=0, miss_r=1; no allocation, no LRU change.
- Write hit: merge the size-wide bytes into the line, set dirty, way becomes MRU, miss_w=0.
- Write miss:
  - Victim = lowest-index invalid way; if all ways are valid, the LRU way.
  - If the victim was valid: evict_valid=1, evict_dirty and evict_tag report the old line.
  - Victim line is zero-filled, the write is merged, valid=1, dirty=1, tag stored, way becomes MRU, miss_w=1.
- Latency: all outputs are registered and valid in the cycle after the accepted edge. Back-to-back ops are allowed every cycle. A read immediately after a write to the same line returns the new data.
- LRU: per-way age counter of log2(WAYS) bits.
  - On touch of way w: every way with age < age[w] increments, then age[w]=0.
  - LRU way = valid way with maximum age; ties go to the lowest index.
  - Ages stay a permutation once all ways are valid.
- Writes with data_size < 3 ignore unused upper bits of write_data.

Optional Feature:
- CACHE_SET_OPCOUNT_EN defined: adds output num_ops (32b).
  - Reset to 0; increments on every accepted op (read or write), wraps at 2^32.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package cache_set_pkg: op encodings (OP_READ, OP_WRITE, OP_NOP), size encodings (SZ_8, SZ_16, SZ_32, SZ_64), LINE_BYTES, OFFSET_W.
- Sub-module cache_set_lru: holds the age counters. Inputs: touch valid, touched way, valid vector. Output: victim way.
- cache_set holds the tag/valid/dirty/data arrays and the byte-merge logic.

Test Plan:
- Reset, then read tag 20, offset 0, size 3 -> next cycle miss_r=1, data_ready=0, out_data=0.
- Write tag 16, offset 0, byte value 3; write tag 25, byte 8 -> each miss_w=1, evict_valid=0. Then read tag 16 size 0 -> out_data=3, data_ready=1; read tag 25 -> out_data=8.
- Write 64b 0x1122334455667788 to tag 7, offset 13 -> stored at aligned offset 8. Read size 1 at offset 10 -> 0x5566. Read size 2 at offset 12 -> 0x11223344.
- Fill 8 tags 0..7 by writes, touch tag 0 by read, then write tag 8 -> evict_valid=1, evict_dirty=1, evict_tag=1. A read of tag 1 then misses.
- set_n != SET_ID, or enable=0, with a write -> no flags set; a later read of that tag misses.
- Assert rst_n=0 in the same cycle as a write -> after reset, a read of that tag misses and all flags are 0.
